// File: rtl/rst_ce_sequencer.sv
// rst_ce_sequencer: hold-then-lock-qualified release of a downstream reset / clock-enable pair
module rst_ce_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int LOCK_FILTER = 3,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_in,
    input  logic       sw_rst,
    output logic       rst_out,
    output logic       ce_out,
    output logic [1:0] seq_state,
    output logic [7:0] relock_cnt
);
    typedef enum logic [1:0] {HOLD = 2'b00, WAIT_LOCK = 2'b01, RUN = 2'b10} state_t;
    state_t state, nxt;
    logic [CNT_W-1:0] hold_cnt, lock_cnt;
    logic lock_ok, lost;
    assign lock_ok = lock_cnt == CNT_W'(LOCK_FILTER);
    assign lost = state == RUN && !lock_in && !sw_rst;
    assign seq_state = state;
    always_comb begin
        nxt = sw_rst ? HOLD :
              state == HOLD ? (hold_cnt == CNT_W'(HOLD_CYCLES - 1) ? WAIT_LOCK : HOLD) :
              state == WAIT_LOCK ? (lock_ok ? RUN : WAIT_LOCK) :
              (state == RUN && lock_in) ? RUN : HOLD;
    end
    // outputs are registered from nxt so they move on the same edge as the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            lock_cnt   <= '0;
            relock_cnt <= '0;
            rst_out    <= 1'b1;
            ce_out     <= 1'b0;
        end else begin
            state      <= nxt;
            hold_cnt   <= (state == HOLD && nxt == HOLD && !sw_rst) ? hold_cnt + 1'b1 : '0;
            lock_cnt   <= !lock_in ? '0 : lock_ok ? lock_cnt : lock_cnt + 1'b1;
            if (lost && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 1'b1;
            rst_out    <= nxt != RUN;
            ce_out     <= nxt == RUN;
        end
    end
endmodule
